// File: rtl/i2c_master_rw.sv
// i2c_master_rw: single-master I2C engine for write, read and
// address-probe transfers, with quarter-period bus timing.
module i2c_master_rw #(
   parameter int CLK_DIV   = 125,
   parameter int MAX_BYTES = 16,
   localparam int CW       = $clog2(MAX_BYTES + 1)
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   output logic          I2C_SCLK,
   inout  wire           I2C_SDAT,
   input  logic          GO,
   input  logic          RW,
   input  logic [6:0]    SLAVE_ADDR,
   input  logic [CW-1:0] NBYTES,
   input  logic [7:0]    TX_DATA,
   input  logic          TX_VALID,
   output logic          TX_READY,
   output logic [7:0]    RX_DATA,
   output logic          RX_VALID,
   output logic          BUSY,
   output logic          DONE,
   output logic          NACK
);

   localparam int QW = $clog2(CLK_DIV);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WDATA,
      WACK, RDATA, RACK, STOP
   } state_t;

   state_t        state;
   logic [QW-1:0] qcnt;
   logic [1:0]    q;
   logic [2:0]    bcnt;
   logic [7:0]    sh;
   logic [CW-1:0] rem;
   logic          rw_r;
   logic          need;
   logic          samp;
   logic          sda_oe;
   logic          tick;

   assign tick     = (qcnt == QW'(CLK_DIV - 1));
   assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         qcnt     <= '0;
         q        <= '0;
         bcnt     <= '0;
         sh       <= '0;
         rem      <= '0;
         rw_r     <= 1'b0;
         need     <= 1'b0;
         samp     <= 1'b1;
         sda_oe   <= 1'b0;
         I2C_SCLK <= 1'b1;
         TX_READY <= 1'b0;
         RX_DATA  <= '0;
         RX_VALID <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         NACK     <= 1'b0;
      end else begin
         TX_READY <= 1'b0;
         RX_VALID <= 1'b0;
         DONE     <= 1'b0;
         if (state == IDLE) begin
            qcnt <= '0;
            if (GO && !DONE) begin
               state    <= START;
               BUSY     <= 1'b1;
               NACK     <= 1'b0;
               q        <= '0;
               I2C_SCLK <= 1'b1;
               sda_oe   <= 1'b0;
               sh       <= {SLAVE_ADDR, RW};
               rw_r     <= RW;
               rem      <= (NBYTES > CW'(MAX_BYTES)) ?
                           CW'(MAX_BYTES) : NBYTES;
            end
         end else if (need) begin
            // q0 of a write byte is stretched until data is offered
            qcnt <= '0;
            if (TX_VALID) begin
               need     <= 1'b0;
               TX_READY <= 1'b1;
               sh       <= TX_DATA;
               sda_oe   <= ~TX_DATA[7];
            end
         end else if (!tick) begin
            qcnt <= qcnt + QW'(1);
         end else begin
            qcnt <= '0;
            q    <= q + 2'd1;
            unique case (state)
               START: begin
                  if (q == 2'd0) begin
                     sda_oe <= 1'b1;
                  end else begin
                     state    <= ADDR;
                     q        <= '0;
                     I2C_SCLK <= 1'b0;
                     sda_oe   <= ~sh[7];
                     bcnt     <= 3'd7;
                  end
               end
               STOP: begin
                  unique case (q)
                     2'd0:    I2C_SCLK <= 1'b1;
                     2'd1:    sda_oe   <= 1'b0;
                     default: begin
                        state <= IDLE;
                        q     <= '0;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                     end
                  endcase
               end
               default: begin
                  unique case (q)
                     2'd1: I2C_SCLK <= 1'b1;
                     2'd2: begin
                        samp <= I2C_SDAT;
                        if (state == RDATA)
                           sh <= {sh[6:0], I2C_SDAT};
                     end
                     2'd3: begin
                        I2C_SCLK <= 1'b0;
                        unique case (state)
                           ADDR, WDATA: begin
                              if (bcnt == 3'd0) begin
                                 state  <= (state == ADDR) ? ADDR_ACK : WACK;
                                 sda_oe <= 1'b0;
                              end else begin
                                 bcnt   <= bcnt - 3'd1;
                                 sh     <= {sh[6:0], 1'b0};
                                 sda_oe <= ~sh[6];
                              end
                           end
                           ADDR_ACK: begin
                              bcnt <= 3'd7;
                              if (samp) begin
                                 NACK   <= 1'b1;
                                 state  <= STOP;
                                 sda_oe <= 1'b1;
                              end else if (rem == '0) begin
                                 state  <= STOP;
                                 sda_oe <= 1'b1;
                              end else begin
                                 state  <= rw_r ? RDATA : WDATA;
                                 need   <= ~rw_r;
                                 sda_oe <= 1'b0;
                              end
                           end
                           WACK: begin
                              bcnt <= 3'd7;
                              rem  <= rem - CW'(1);
                              if (samp) begin
                                 NACK   <= 1'b1;
                                 state  <= STOP;
                                 sda_oe <= 1'b1;
                              end else if (rem == CW'(1)) begin
                                 state  <= STOP;
                                 sda_oe <= 1'b1;
                              end else begin
                                 state  <= WDATA;
                                 need   <= 1'b1;
                                 sda_oe <= 1'b0;
                              end
                           end
                           RDATA: begin
                              if (bcnt == 3'd0) begin
                                 state    <= RACK;
                                 RX_DATA  <= sh;
                                 RX_VALID <= 1'b1;
                                 rem      <= rem - CW'(1);
                                 sda_oe   <= (rem != CW'(1));
                              end else begin
                                 bcnt <= bcnt - 3'd1;
                              end
                           end
                           RACK: begin
                              bcnt   <= 3'd7;
                              state  <= (rem == '0) ? STOP : RDATA;
                              sda_oe <= (rem == '0);
                           end
                           default: ;
                        endcase
                     end
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_rw.sv
// tb_i2c_master_rw: randomized transfers against an I2C slave model
// with a transaction-level scoreboard for bus bytes, RX and DONE.
module tb_i2c_master_rw;

   localparam int CLKD = 4;
   localparam int MAXB = 4;
   localparam int CW   = $clog2(MAXB + 1);
   localparam int LIM  = 20000;

   typedef struct {
      int nack;
      int ntx;
      int rises;
   } done_t;

   logic          CLOCK;
   logic          RESET_N;
   logic          scl;
   wire           sda;
   logic          GO;
   logic          RW;
   logic [6:0]    SLAVE_ADDR;
   logic [CW-1:0] NBYTES;
   logic [7:0]    TX_DATA;
   logic          TX_VALID;
   logic          TX_READY;
   logic [7:0]    RX_DATA;
   logic          RX_VALID;
   logic          BUSY;
   logic          DONE;
   logic          NACK;

   logic          sl_drive;
   int            gen;
   int            rd_pos;
   int            cyc;
   int            stop_seen;
   int            vectors;
   int            errs;

   logic [7:0]    dat_q[$];
   logic [7:0]    rd_q[$];
   logic [8:0]    exp_bus[$];
   logic [7:0]    exp_rx[$];
   done_t         exp_done[$];

   pullup (sda);
   assign sda = sl_drive ? 1'b0 : 1'bz;

   i2c_master_rw #(.CLK_DIV(CLKD), .MAX_BYTES(MAXB)) dut (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .I2C_SCLK   (scl),
      .I2C_SDAT   (sda),
      .GO         (GO),
      .RW         (RW),
      .SLAVE_ADDR (SLAVE_ADDR),
      .NBYTES     (NBYTES),
      .TX_DATA    (TX_DATA),
      .TX_VALID   (TX_VALID),
      .TX_READY   (TX_READY),
      .RX_DATA    (RX_DATA),
      .RX_VALID   (RX_VALID),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .NACK       (NACK)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(string name);
      vectors++;
      errs++;
      $display("FAIL %s: event seen with nothing expected", name);
   endtask

   // Passive monitor for strobes, DONE status and SCL edge count
   task automatic monitor();
      done_t d;
      int    txr;
      int    rises;
      logic  sclp;
      txr   = 0;
      rises = 0;
      sclp  = 1'b1;
      forever begin
         @(negedge CLOCK);
         cyc++;
         if (scl && !sclp) rises++;
         sclp = scl;
         if (TX_READY) txr++;
         if (RX_VALID) begin
            if (exp_rx.size() == 0) flag("rx_unexpected");
            else check("rx_data", RX_DATA, exp_rx.pop_front());
         end
         if (DONE) begin
            if (exp_done.size() == 0) begin
               flag("done_unexpected");
            end else begin
               d = exp_done.pop_front();
               check("done_nack", NACK, d.nack);
               check("tx_ready_count", txr, d.ntx);
               check("scl_rises", rises, d.rises);
               check("stop_seen", stop_seen, 1);
            end
            txr       = 0;
            rises     = 0;
            stop_seen = 0;
         end
         if (!RESET_N) begin
            txr   = 0;
            rises = 0;
         end
      end
   endtask

   task automatic bus_cmp(logic [8:0] e);
      if (exp_bus.size() == 0) flag("bus_extra");
      else check("bus_byte", e, exp_bus.pop_front());
   endtask

   // I2C slave; a stale instance returns once gen moves on
   task automatic slave(int id, bit rw, bit ack, int n);
      logic [7:0] rd[$];
      logic [7:0] b;
      int         nb;
      int         t0;
      rd = rd_q;
      b  = '0;
      t0 = 0;
      @(negedge sda iff scl === 1'b1);
      if (id != gen) return;
      nb = ack ? n + 1 : 1;
      for (int k = 0; k < nb; k++) begin
         if (k == 0 || !rw) begin
            for (int i = 0; i < 8; i++) begin
               @(posedge scl);
               if (id != gen) return;
               if (k == 0 && i == 6) t0 = cyc;
               if (k == 0 && i == 7) check("scl_period", cyc - t0, 4 * CLKD);
               b = {b[6:0], sda};
            end
            @(negedge scl);
            if (id != gen) return;
            sl_drive = (k == 0) ? ack : 1'b1;
            @(posedge scl);
            if (id != gen) return;
            bus_cmp({b, sda});
            @(negedge scl);
            if (id != gen) return;
            sl_drive = 1'b0;
         end else begin
            b = rd[k-1];
            for (int i = 0; i < 8; i++) begin
               sl_drive = ~b[7-i];
               rd_pos   = k * 8 + i;
               @(posedge scl);
               if (id != gen) return;
               @(negedge scl);
               if (id != gen) return;
            end
            sl_drive = 1'b0;
            @(posedge scl);
            if (id != gen) return;
            bus_cmp({b, sda});
            @(negedge scl);
            if (id != gen) return;
         end
      end
      @(posedge sda iff scl === 1'b1);
      if (id != gen) return;
      stop_seen = 1;
   endtask

   task automatic tx_drive(bit rw, int n, bit stall);
      int   falls;
      int   hi;
      logic p;
      if (rw) return;
      for (int i = 0; i < n; i++) begin
         if (stall && i == 1) begin
            TX_VALID = 1'b0;
            falls    = 0;
            p        = scl;
            for (int c = 0; c < LIM && falls < 9; c++) begin
               @(negedge CLOCK);
               if (p && !scl) falls++;
               p = scl;
            end
            hi = 0;
            repeat (50) begin
               @(negedge CLOCK);
               if (scl) hi++;
            end
            check("stall_scl_low", hi, 0);
         end
         TX_DATA  = dat_q[i];
         TX_VALID = 1'b1;
         for (int c = 0; c < LIM; c++) begin
            @(negedge CLOCK);
            if (TX_READY || DONE) break;
         end
         if (DONE) break;
      end
      TX_VALID = 1'b0;
   endtask

   task automatic wait_done();
      for (int c = 0; c < LIM; c++) begin
         @(negedge CLOCK);
         if (DONE === 1'b1) return;
      end
      flag("done_timeout");
   endtask

   task automatic abort_mid_read();
      int seen;
      seen = 0;
      for (int c = 0; c < LIM; c++) begin
         @(negedge CLOCK);
         if (rd_pos == 11) begin
            seen = 1;
            break;
         end
      end
      if (seen == 0) flag("rdata_bit4_timeout");
      repeat (2) @(negedge CLOCK);
      gen++;
      sl_drive = 1'b0;
      RESET_N  = 1'b0;
      #1;
      check("reset_scl", scl, 1);
      check("reset_sda", sda, 1);
      check("reset_busy", BUSY, 0);
      check("reset_rx_data", RX_DATA, 0);
      exp_bus.delete();
      exp_rx.delete();
      repeat (3) @(negedge CLOCK);
      RESET_N = 1'b1;
      repeat (100) @(negedge CLOCK);
      check("idle_after_abort", BUSY, 0);
   endtask

   task automatic run_txn(bit rw, logic [6:0] addr, int n, bit ack,
                          bit stall, bit go_again, bit abort);
      int    ne;
      int    nb;
      done_t d;
      repeat (3) @(negedge CLOCK);
      ne = (n > MAXB) ? MAXB : n;
      exp_bus.push_back({addr, rw, ~ack});
      if (ack) begin
         for (int i = 0; i < ne; i++) begin
            if (!rw) begin
               exp_bus.push_back({dat_q[i], 1'b0});
            end else begin
               exp_bus.push_back({dat_q[i], i == ne - 1});
               exp_rx.push_back(dat_q[i]);
            end
         end
      end
      nb      = ack ? ne + 1 : 1;
      d.nack  = ack ? 0 : 1;
      d.ntx   = (ack && !rw) ? ne : 0;
      d.rises = 9 * nb + 1;
      if (!abort) exp_done.push_back(d);
      gen++;
      sl_drive = 1'b0;
      rd_q     = dat_q;
      rd_pos   = -1;
      fork
         slave(gen, rw, ack, ne);
      join_none
      SLAVE_ADDR = addr;
      RW         = rw;
      NBYTES     = CW'(n);
      TX_VALID   = 1'b0;
      GO         = 1'b1;
      @(negedge CLOCK);
      GO = 1'b0;
      check("busy_after_go", BUSY, 1);
      check("nack_clear_at_go", NACK, 0);
      if (abort) begin
         abort_mid_read();
         return;
      end
      fork
         tx_drive(rw, ne, stall);
         wait_done();
         begin
            if (go_again) begin
               repeat (40) @(negedge CLOCK);
               SLAVE_ADDR = addr ^ 7'h7F;
               RW         = ~rw;
               GO         = 1'b1;
               @(negedge CLOCK);
               GO = 1'b0;
            end
         end
      join
   endtask

   task automatic fill_rand(int n);
      dat_q.delete();
      for (int i = 0; i < n; i++) dat_q.push_back(8'($urandom));
   endtask

   initial begin
      vectors    = 0;
      errs       = 0;
      gen        = 0;
      cyc        = 0;
      stop_seen  = 0;
      rd_pos     = -1;
      sl_drive   = 1'b0;
      RESET_N    = 1'b0;
      GO         = 1'b0;
      RW         = 1'b0;
      SLAVE_ADDR = '0;
      NBYTES     = '0;
      TX_DATA    = '0;
      TX_VALID   = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge CLOCK);
      check("rst_scl", scl, 1);
      check("rst_sda", sda, 1);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_nack", NACK, 0);
      check("rst_tx_ready", TX_READY, 0);
      check("rst_rx_valid", RX_VALID, 0);
      check("rst_rx_data", RX_DATA, 0);
      RESET_N = 1'b1;

      dat_q = '{8'h34, 8'h56};
      run_txn(1'b0, 7'h1A, 2, 1'b1, 1'b0, 1'b0, 1'b0);

      dat_q = '{8'hA5, 8'h5A, 8'hFF};
      run_txn(1'b1, 7'h50, 3, 1'b1, 1'b0, 1'b1, 1'b0);

      dat_q = '{8'h11, 8'h22};
      run_txn(1'b0, 7'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (20) @(negedge CLOCK);
      check("nack_held", NACK, 1);

      dat_q = '{8'hC3, 8'h3C};
      run_txn(1'b0, 7'h2B, 2, 1'b1, 1'b1, 1'b0, 1'b0);
      GO = 1'b1;
      @(negedge CLOCK);
      GO = 1'b0;
      check("go_at_done_ignored", BUSY, 0);

      dat_q.delete();
      run_txn(1'b0, 7'h3C, 0, 1'b1, 1'b0, 1'b0, 1'b0);

      fill_rand(2);
      run_txn(1'b1, 7'h47, 2, 1'b1, 1'b0, 1'b0, 1'b1);
      fill_rand(2);
      run_txn(1'b1, 7'h47, 2, 1'b1, 1'b0, 1'b0, 1'b0);

      fill_rand(MAXB);
      run_txn(1'b0, 7'h61, 7, 1'b1, 1'b0, 1'b0, 1'b0);
      fill_rand(MAXB);
      run_txn(1'b1, 7'h19, 6, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         int n;
         n = $urandom_range(0, 7);
         fill_rand(MAXB);
         run_txn(1'($urandom), 7'($urandom), n,
                 $urandom_range(0, 4) != 0, 1'b0, 1'b0, 1'b0);
      end

      repeat (20) @(negedge CLOCK);
      check("scoreboard_drained",
            exp_bus.size() + exp_rx.size() + exp_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/i2c_master_rw.md
I2C_MASTER_RW -- requirements
Module: i2c_master_rw

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning CLOCK cycles per quarter SCL period (min 2).
REQ-002 SHALL have parameter MAX_BYTES, default 16, meaning the largest transfer length; CW = clog2(MAX_BYTES+1).
REQ-003 SHALL have port CLOCK  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port I2C_SCLK  out  1  SCL; driven high or low.
REQ-006 SHALL have port I2C_SDAT  inout  1  SDA; open-drain: drives 0 or Z only.
REQ-007 SHALL have port GO  in  1  one-cycle start request, honoured only in IDLE.
REQ-008 SHALL have port RW  in  1  direction, latched at GO: 0 write, 1 read.
REQ-009 SHALL have port SLAVE_ADDR  in  7  7-bit target address, latched at GO.
REQ-010 SHALL have port NBYTES  in  CW  data-byte count, latched at GO; 0 = address-only probe.
REQ-011 SHALL have port TX_DATA  in  8  next write byte.
REQ-012 SHALL have port TX_VALID  in  1  TX_DATA valid.
REQ-013 SHALL have port TX_READY  out  1  one-cycle byte-accept strobe.
REQ-014 SHALL have port RX_DATA  out  8  last byte read.
REQ-015 SHALL have port RX_VALID  out  1  one-cycle strobe, RX_DATA new.
REQ-016 SHALL have port BUSY  out  1  high from GO acceptance to DONE.
REQ-017 SHALL have port DONE  out  1  one-cycle strobe at end of transfer.
REQ-018 SHALL have port NACK  out  1  held status of last transfer: slave NACKed; cleared at next GO.

Function
REQ-019 SHALL derive a one-cycle quarter tick from a counter wrapping at CLK_DIV-1, running only when not IDLE; all bus changes occur on ticks.
REQ-020 SHALL use FSM states IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP.
REQ-021 SHALL give each bit four quarters: q0 SCL low, SDA updated; q1 SCL low; q2 SCL high; q3 SCL high, SDA sampled at q3 entry.
REQ-022 SHALL in START: SDA released, SCL high for one quarter; SDA low for one quarter; then SCL low.
REQ-023 SHALL in ADDR: shift {SLAVE_ADDR,RW} MSB first, then ADDR_ACK releases SDA and samples it.
REQ-024 SHALL, on ADDR_ACK sample 1: set NACK, go to STOP; on 0: go to STOP if NBYTES=0, else WDATA (RW=0) or RDATA (RW=1).
REQ-025 SHALL in WDATA, at q0 of bit 7: if TX_VALID=1, pulse TX_READY and load TX_DATA; if TX_VALID=0, hold SCL low and stall the quarter counter until TX_VALID=1.
REQ-026 SHALL in WACK: on sample 1 set NACK and go to STOP, abandoning remaining bytes; on 0 decrement the remaining count and go to STOP at zero, else WDATA.
REQ-027 SHALL in RDATA: release SDA and shift in 8 bits MSB first; at end, update RX_DATA and pulse RX_VALID.
REQ-028 SHALL in RACK: drive SDA 0 (ACK) if bytes remain, release it (NACK) on the last byte; never set NACK.
REQ-029 SHALL in STOP: SCL low with SDA low; SCL high; SDA released; then pulse DONE, clear BUSY, and enter IDLE in the same cycle.
REQ-030 SHALL treat NBYTES > MAX_BYTES as MAX_BYTES.
REQ-031 SHALL ignore GO while BUSY=1.
REQ-032 SHALL, when GO and DONE coincide, ignore GO; GO is accepted from the next cycle.
REQ-033 SHALL hold TX_READY=0 and RX_VALID=0 outside WDATA and RDATA respectively.
REQ-034 SHALL in IDLE hold I2C_SCLK=1 and I2C_SDAT=Z.

Reset
REQ-035 SHALL on RESET_N=0 immediately force: state IDLE, I2C_SCLK=1, I2C_SDAT=Z, BUSY=0, DONE=0, NACK=0, TX_READY=0, RX_VALID=0, RX_DATA=0, tick counter 0.
REQ-036 SHALL on reset mid-transfer abort with no STOP generated and no DONE pulse.

Verification
REQ-037 SHALL cover: CLK_DIV=4, write addr 0x1A, NBYTES=2, bytes 0x34,0x56, slave ACKs all -> SDA bits 0x34,0x56 on the bus; two TX_READY pulses; DONE once; NACK=0; SCL period 16 cycles.
REQ-038 SHALL cover: read addr 0x50, NBYTES=3, slave returns 0xA5,0x5A,0xFF -> three RX_VALID pulses with those values; master ACK,ACK,NACK; STOP; DONE.
REQ-039 SHALL cover: address 0x22 unacknowledged (SDA high at ACK) -> NACK=1, no TX_READY, STOP, DONE; a following GO clears NACK.
REQ-040 SHALL cover: write NBYTES=2, TX_VALID low for 50 cycles before byte 2 -> SCL held low throughout the stall, bus timing resumes intact, DONE.
REQ-041 SHALL cover: RESET_N low during RDATA bit 4 -> SCL=1, SDA=Z, BUSY=0 in the same cycle; no DONE; the next GO completes normally.
REQ-042 SHALL cover: NBYTES=0 probe to 0x3C with ACK -> START, 9 SCL pulses, STOP, DONE, NACK=0.
